// File: rtl/ir_burst_sequencer.sv
// ir_burst_sequencer
// Schedules timed IR carrier bursts: a host command (frequency code,
// on-time, off-time, repetition count) becomes a train of emit_en bursts
// separated by gaps. Durations are counted in millisecond ticks derived
// from the system clock by a TICK_DIV prescaler.
//
// Command handshake: start is a single-cycle strobe that is only looked at
// while the block is idle (busy=0); when it is accepted the cmd_* inputs
// are captured on that same edge and may change freely afterwards. abort
// cancels a running sequence on the edge it is seen and wins over start.
// done is a one-cycle pulse on normal completion (or a no-op command);
// it never follows an abort.
//
// All outputs come straight from flops. dbg_state mirrors the FSM state
// register for observation.

module ir_burst_sequencer #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  cmd_freq,
  input  logic [15:0] cmd_on_ms,
  input  logic [15:0] cmd_off_ms,
  input  logic [7:0]  cmd_reps,
  output logic [1:0]  freq_sel,
  output logic        emit_en,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_q, ms_d;
  logic [7:0]    rep_q, rep_d;
  logic [15:0]   on_q, on_d;
  logic [15:0]   off_q, off_d;
  logic [7:0]    reps_q, reps_d;
  logic [1:0]    freq_q, freq_d;
  logic          emit_q, emit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tick;
  logic          burst_end;
  logic          gap_end;
  logic          cmd_noop;
  logic [1:0]    cmd_freq_mapped;

  // One ms has elapsed when the prescaler sits on its last count.
  assign tick      = (presc_q == PRESC_MAX);
  // Last cycle of a burst / gap: final prescaler count of the final ms.
  assign burst_end = tick && (ms_q == (on_q - 16'd1));
  assign gap_end   = tick && (ms_q == (off_q - 16'd1));
  // Zero bursts or zero-length bursts produce nothing but a done pulse.
  assign cmd_noop  = (cmd_reps == 8'd0) || (cmd_on_ms == 16'd0);
  // Code 11 is not a valid emitter frequency; fall back to 1 kHz.
  assign cmd_freq_mapped = (cmd_freq == 2'b11) ? 2'b00 : cmd_freq;

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    rep_d   = rep_q;
    on_d    = on_q;
    off_d   = off_q;
    reps_d  = reps_q;
    freq_d  = freq_q;
    emit_d  = emit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        ms_d    = '0;
        emit_d  = 1'b0;
        busy_d  = 1'b0;
        if (start && !abort) begin
          if (cmd_noop) begin
            done_d = 1'b1;
          end else begin
            on_d    = cmd_on_ms;
            off_d   = cmd_off_ms;
            reps_d  = cmd_reps;
            freq_d  = cmd_freq_mapped;
            rep_d   = 8'd1;
            emit_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = S_ON;
          end
        end
      end

      S_ON: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        ms_d    = tick ? ms_q + 16'd1 : ms_q;
        if (abort) begin
          presc_d = '0;
          ms_d    = '0;
          emit_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (burst_end) begin
          presc_d = '0;
          ms_d    = '0;
          if (rep_q == reps_q) begin
            emit_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (off_q == 16'd0) begin
            // Back-to-back bursts: carrier stays gated on, count restarts.
            rep_d = rep_q + 8'd1;
          end else begin
            emit_d  = 1'b0;
            state_d = S_OFF;
          end
        end
      end

      S_OFF: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        ms_d    = tick ? ms_q + 16'd1 : ms_q;
        if (abort) begin
          presc_d = '0;
          ms_d    = '0;
          emit_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (gap_end) begin
          presc_d = '0;
          ms_d    = '0;
          rep_d   = rep_q + 8'd1;
          emit_d  = 1'b1;
          state_d = S_ON;
        end
      end

      default: begin
        presc_d = '0;
        ms_d    = '0;
        emit_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, latched command and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      rep_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      reps_q  <= '0;
      freq_q  <= 2'b00;
      emit_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      rep_q   <= rep_d;
      on_q    <= on_d;
      off_q   <= off_d;
      reps_q  <= reps_d;
      freq_q  <= freq_d;
      emit_q  <= emit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign freq_sel  = freq_q;
  assign emit_en   = emit_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/ir_burst_sequencer.md
# ir_burst_sequencer

Schedules timed IR carrier bursts for the emitter. A host issues a one-shot command (frequency code, on-time, off-time, repetition count). The block drives the emitter's `freq_sel` and a gating enable (`emit_en`), which the top level ANDs with the emitter's `drive` output. All burst and gap durations are counted in millisecond ticks derived from the 100 MHz system clock.

## Interface
- `TICK_DIV`, 100000, clk cycles per 1 ms tick (must be ≥ 2; benches override it to 4)
- `clk`  in  1  100 MHz system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  command strobe; sampled only in IDLE
- `abort`  in  1  cancels an active sequence; has priority over `start`
- `cmd_freq`  in  2  emitter frequency code (00 = 1 kHz, 01 = 2 kHz, 10 = 3 kHz, 11 mapped to 00)
- `cmd_on_ms`  in  16  burst length in ms
- `cmd_off_ms`  in  16  gap length in ms between bursts
- `cmd_reps`  in  8  number of bursts
- `freq_sel`  out  2  to emitter; held for the whole sequence
- `emit_en`  out  1  carrier gate; 1 during bursts
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, ON, OFF.
- `cmd_*` are latched when `start` is accepted. Later changes to `cmd_*` have no effect on the running sequence.
- In IDLE with `start`=1 and `abort`=0:
  - If `cmd_reps`=0 or `cmd_on_ms`=0: the command is a no-op. `done` pulses on that edge, `busy` stays 0, `emit_en` stays 0, and the state remains IDLE.
  - Otherwise: latch the command, load `freq_sel` (11→00), set `busy`=1 and `emit_en`=1, enter ON, and set the rep counter to 1.
- ON:
  - Lasts exactly `on_ms`×`TICK_DIV` cycles.
  - At the end, if the rep counter equals `reps`: go to IDLE, clear `emit_en` and `busy`, and pulse `done`.
  - Else, if `off_ms`=0: stay in ON (restart the ms count), increment the rep counter, and keep `emit_en` high.
  - Else: go to OFF and clear `emit_en`.
- OFF:
  - Lasts exactly `off_ms`×`TICK_DIV` cycles.
  - Then go to ON, set `emit_en`=1, and increment the rep counter.
- There is no trailing gap after the final burst.
- Counters:
  - Cycle prescaler: ⌈log2 TICK_DIV⌉ bits, wraps at `TICK_DIV`−1 and emits a tick.
  - 16-bit ms counter and 8-bit rep counter.
  - Both the prescaler and the ms counter clear on every state entry and every burst restart, so durations are exact and never fractional.
- Abort in ON or OFF:
  - On that edge, go to IDLE with `emit_en`=0 and `busy`=0.
  - No `done` pulse.
  - `freq_sel` keeps its value.
- `abort` in IDLE is ignored.
- `start` while `busy` is ignored.
- In IDLE, `freq_sel` retains the last loaded value.
- `rst`: at the next edge, state=IDLE and all counters clear. This applies mid-sequence as well.

## Timing
- Reset values: `freq_sel`=00, `emit_en`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `start` accepted at edge k → `freq_sel`, `emit_en`, and `busy` are valid from edge k (zero added latency).
- `emit_en` high time per burst is exactly `on_ms`×`TICK_DIV` cycles; low time per gap is exactly `off_ms`×`TICK_DIV` cycles.
- `busy` high time = `reps`×`on`×D + (`reps`−1)×`off`×D cycles, where D=`TICK_DIV`.
- `done`, the fall of `busy`, and the final fall of `emit_en` all occur on the same edge.
- A new `start` is accepted on the edge after `busy` falls, including the edge immediately after an abort.
- `freq_sel` changes only on the edge that accepts a `start`. It never changes mid-burst, so the emitter period is never disturbed.

## Test plan
All tests use D=`TICK_DIV`=4.
1. Reset: hold `rst` for 3 cycles with `start`=1 → `freq_sel`=00, `emit_en`=0, `busy`=0, `done`=0 throughout.
2. Nominal: `start` with freq=01, on=2, off=1, reps=3 → `freq_sel`=01; `emit_en` pattern 8 high / 4 low / 8 / 4 / 8; `busy` high for 32 cycles; exactly one `done` pulse on the edge where `busy` falls.
3. No-op commands: `start` with reps=0, then `start` with reps=2 and on=0 → each gives a `done` pulse on the accepting edge; `busy` and `emit_en` never rise.
4. Abort: start freq=10, on=3, off=2, reps=4; assert `abort` in the 5th cycle of burst 2 → next edge `emit_en`=0 and `busy`=0 with no `done`; `start` on the following cycle is accepted normally.
5. Ignored and degenerate inputs:
   - During a busy sequence with freq=00, pulse `start` with freq=01 and change `cmd_on_ms` → `freq_sel` stays 00 and timing is unchanged.
   - freq=11, on=1, off=0, reps=5 → `freq_sel`=00 and `emit_en` continuously high for 20 cycles.
6. Reset mid-OFF of a reps=3 sequence → next edge all outputs at reset values, no `done`; a fresh command afterward runs with full-length bursts.
